// File: rtl/packet_rx.sv
// Ingress parser: checks each packet header from the generator, writes accepted packets
// into a circular word buffer and emits one metadata record per completed packet.
module packet_rx #(
    parameter int BUF_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [31:0]       pkt_data,
    input  logic              rel_valid,
    input  logic [9:0]        rel_words,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              meta_valid,
    output logic [1:0]        meta_src,
    output logic [1:0]        meta_dst,
    output logic [5:0]        meta_len,
    output logic [ADDR_W-1:0] meta_addr,
    output logic [21:0]       meta_ts,
    output logic [15:0]       drop_cnt,
    output logic [ADDR_W:0]   free_words
);

    typedef enum logic [2:0] {
        HDR0, HDR1, TS0, TS1, SMAC0, SMAC1, PAYLOAD, DROP
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_WORDS = (ADDR_W+1)'(BUF_DEPTH);

    state_t            state, next_state;
    logic [9:0]        remaining, next_remaining;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   used, used_after_rel, rel_ext;

    // Header fields collected while the packet streams in, published on its last word.
    logic [1:0]        pend_src, pend_dst;
    logic [5:0]        pend_len;
    logic [ADDR_W-1:0] pend_addr;
    logic [21:0]       pend_ts;

    logic [15:0]       hdr_len;
    logic              len_legal;
    logic [ADDR_W:0]   hdr_words;
    logic              at_word0;
    logic              accept_word, last_word, start_pkt, drop_pkt;

    assign hdr_len    = pkt_data[31:16];
    assign len_legal  = (hdr_len != 16'd0) && (hdr_len[4:0] == 5'd0) && (hdr_len <= 16'd2048);
    assign hdr_words  = (ADDR_W+1)'(hdr_len[11:2]);
    assign free_words = DEPTH_WORDS - used;
    assign rel_ext    = (ADDR_W+1)'(rel_words);

    // An illegal length parks in DROP with nothing left to skip, so the very next
    // valid word is parsed as a fresh word 0.
    assign at_word0 = (state == HDR0) || ((state == DROP) && (remaining == 10'd0));

    // Accept decisions use free_words from before this cycle's release.
    assign used_after_rel = !rel_valid        ? used :
                            (rel_ext > used)  ? '0   : used - rel_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HDR0;
            remaining <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            state     <= next_state;
            remaining <= next_remaining;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        next_state     = state;
        next_remaining = remaining;
        accept_word    = 1'b0;
        last_word      = 1'b0;
        start_pkt      = 1'b0;
        drop_pkt       = 1'b0;
        if (pkt_valid) begin
            if (at_word0) begin
                if (!len_legal) begin
                    drop_pkt       = 1'b1;
                    next_state     = DROP;
                    next_remaining = 10'd0;
                end else if (hdr_words > free_words) begin
                    drop_pkt       = 1'b1;
                    next_state     = DROP;
                    next_remaining = 10'(hdr_words - 1'b1);
                end else begin
                    start_pkt      = 1'b1;
                    accept_word    = 1'b1;
                    next_state     = HDR1;
                    next_remaining = 10'(hdr_words - 1'b1);
                end
            end else begin
                next_remaining = remaining - 10'd1;
                case (state)
                    HDR1:  begin accept_word = 1'b1; next_state = TS0;     end
                    TS0:   begin accept_word = 1'b1; next_state = TS1;     end
                    TS1:   begin accept_word = 1'b1; next_state = SMAC0;   end
                    SMAC0: begin accept_word = 1'b1; next_state = SMAC1;   end
                    SMAC1: begin accept_word = 1'b1; next_state = PAYLOAD; end
                    PAYLOAD: begin
                        accept_word = 1'b1;
                        if (remaining == 10'd1) begin
                            last_word  = 1'b1;
                            next_state = HDR0;
                        end
                    end
                    DROP: begin
                        if (remaining == 10'd1) next_state = HDR0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_ptr     <= '0;
            used       <= '0;
            drop_cnt   <= '0;
            meta_valid <= 1'b0;
            meta_src   <= '0;
            meta_dst   <= '0;
            meta_len   <= '0;
            meta_addr  <= '0;
            meta_ts    <= '0;
            pend_src   <= '0;
            pend_dst   <= '0;
            pend_len   <= '0;
            pend_addr  <= '0;
            pend_ts    <= '0;
        end else begin
            wr_en      <= accept_word;
            meta_valid <= last_word;
            used       <= used_after_rel + (start_pkt ? hdr_words : '0);

            if (accept_word) begin
                wr_addr <= wr_ptr;
                wr_data <= pkt_data;
                wr_ptr  <= wr_ptr + 1'b1;
            end

            if (drop_pkt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

            if (start_pkt) begin
                pend_addr <= wr_ptr;
                pend_len  <= 6'(hdr_len[11:5] - 7'd1);
            end
            if (accept_word) begin
                case (state)
                    HDR1:    pend_dst <= pkt_data[1:0];
                    TS0:     pend_ts  <= pkt_data[21:0];
                    SMAC0:   pend_src <= pkt_data[1:0];
                    default: ;
                endcase
            end

            if (last_word) begin
                meta_src  <= pend_src;
                meta_dst  <= pend_dst;
                meta_len  <= pend_len;
                meta_addr <= pend_addr;
                meta_ts   <= pend_ts;
            end
        end
    end

endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx: a packet table plus hand sequences for
// buffer wrap, full buffer and reset mid-payload.
module tb_packet_rx;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        rel_valid;
    logic [9:0]  rel_words;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        meta_valid;
    logic [1:0]  meta_src, meta_dst;
    logic [5:0]  meta_len;
    logic [9:0]  meta_addr;
    logic [21:0] meta_ts;
    logic [15:0] drop_cnt;
    logic [10:0] free_words;

    packet_rx dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .rel_valid(rel_valid), .rel_words(rel_words),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .meta_valid(meta_valid), .meta_src(meta_src), .meta_dst(meta_dst),
        .meta_len(meta_len), .meta_addr(meta_addr), .meta_ts(meta_ts),
        .drop_cnt(drop_cnt), .free_words(free_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_rec_t;

    typedef struct {
        logic [1:0]  src, dst;
        logic [5:0]  len;
        logic [9:0]  addr;
        logic [21:0] ts;
        logic        with_wr;
        int          wr_idx;
        logic [31:0] data;
    } meta_rec_t;

    typedef struct {
        bit          do_reset;
        logic [15:0] len;
        logic [1:0]  dst, src;
        logic [21:0] ts;
        bit          gapped;
        int          rel_at;
        logic [9:0]  rel_n;
        bit          exp_acc;
        int          exp_addr;
        logic [5:0]  exp_len;
        int          exp_drop;
        int          exp_free;
    } vec_t;

    wr_rec_t     wr_log[$];
    meta_rec_t   meta_log[$];
    logic [31:0] pkt_q[$];
    logic [1:0]  cur_dst, cur_src;
    logic [21:0] cur_ts;
    int          pkt_seq = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs[8];

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back('{wr_addr, wr_data});
        if (meta_valid)
            meta_log.push_back('{meta_src, meta_dst, meta_len, meta_addr, meta_ts,
                                 wr_en, wr_log.size(), wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        pkt_valid = 1'b0;
        rel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Illegal lengths produce a lone word 0; legal ones the full L/4 words.
    task automatic build_packet(input logic [15:0] len, input logic [1:0] dst,
                                input logic [1:0] src, input logic [21:0] ts);
        int n;
        bit legal;
        legal = (len != 0) && (len % 32 == 0) && (len <= 2048);
        n = legal ? int'(len) / 4 : 1;
        pkt_seq++;
        cur_dst = dst;
        cur_src = src;
        cur_ts  = ts;
        pkt_q.delete();
        wr_log.delete();
        meta_log.delete();
        for (int i = 0; i < n; i++) begin
            case (i)
                0: pkt_q.push_back({len, 16'hA5C3});
                1: pkt_q.push_back({30'h1357_9BDF, dst});
                2: pkt_q.push_back({10'h3A5, ts});
                3: pkt_q.push_back(32'h0BAD_CAFE);
                4: pkt_q.push_back({30'h2468_ACE0, src});
                5: pkt_q.push_back(32'h5555_AAAA);
                default: pkt_q.push_back({8'hD0, 8'(pkt_seq), 16'(i)});
            endcase
        end
    endtask

    task automatic drive_words(input bit gapped, input int rel_at, input logic [9:0] rel_n);
        foreach (pkt_q[i]) begin
            @(posedge clk); #1;
            pkt_valid = 1'b1;
            pkt_data  = pkt_q[i];
            rel_valid = (i == rel_at);
            rel_words = (i == rel_at) ? rel_n : 10'd0;
            if (gapped) begin
                @(posedge clk); #1;
                pkt_valid = 1'b0;
                pkt_data  = 32'hDEAD_BEEF;
                rel_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        rel_valid = 1'b0;
        rel_words = 10'd0;
    endtask

    task automatic release_words(input logic [9:0] n);
        @(posedge clk); #1;
        rel_valid = 1'b1;
        rel_words = n;
        @(posedge clk); #1;
        rel_valid = 1'b0;
        rel_words = 10'd0;
    endtask

    task automatic check_packet(input string tag, input bit exp_acc, input int exp_addr,
                                input logic [5:0] exp_len);
        int n;
        n = exp_acc ? pkt_q.size() : 0;
        check($sformatf("%s write count", tag), wr_log.size(), n);
        foreach (wr_log[i]) begin
            if (i < n) begin
                check($sformatf("%s wr_addr[%0d]", tag, i), wr_log[i].addr, (exp_addr + i) % DEPTH);
                check($sformatf("%s wr_data[%0d]", tag, i), wr_log[i].data, pkt_q[i]);
            end
        end
        check($sformatf("%s meta count", tag), meta_log.size(), exp_acc ? 1 : 0);
        if (exp_acc && meta_log.size() > 0) begin
            check($sformatf("%s meta_src", tag),  meta_log[0].src, cur_src);
            check($sformatf("%s meta_dst", tag),  meta_log[0].dst, cur_dst);
            check($sformatf("%s meta_len", tag),  meta_log[0].len, exp_len);
            check($sformatf("%s meta_addr", tag), meta_log[0].addr, exp_addr);
            check($sformatf("%s meta_ts", tag),   meta_log[0].ts, cur_ts);
            check($sformatf("%s meta with last wr_en", tag), meta_log[0].with_wr, 1);
            check($sformatf("%s meta at write #", tag), meta_log[0].wr_idx, n);
            check($sformatf("%s meta wr_data", tag), meta_log[0].data, pkt_q[n-1]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             rst   len     dst   src   ts          gap  rel rel_n  acc addr len   drop free
        vecs[0] = '{1'b1, 16'd32,   2'd2, 2'd1, 22'h2A5A5A, 1'b0, -1, 10'd0, 1'b1, 0,  6'd0, 0, 1016};
        vecs[1] = '{1'b1, 16'd64,   2'd3, 2'd2, 22'h001234, 1'b1, -1, 10'd0, 1'b1, 0,  6'd1, 0, 1008};
        vecs[2] = '{1'b0, 16'd32,   2'd1, 2'd3, 22'h3FFFFF, 1'b0,  0, 10'd8, 1'b1, 16, 6'd0, 0, 1008};
        vecs[3] = '{1'b0, 16'd40,   2'd0, 2'd0, 22'h000000, 1'b0, -1, 10'd0, 1'b0, 0,  6'd0, 1, 1008};
        vecs[4] = '{1'b0, 16'd32,   2'd0, 2'd0, 22'h000001, 1'b0, -1, 10'd0, 1'b1, 24, 6'd0, 1, 1000};
        vecs[5] = '{1'b0, 16'd0,    2'd0, 2'd0, 22'h000000, 1'b0, -1, 10'd0, 1'b0, 0,  6'd0, 2, 1000};
        vecs[6] = '{1'b0, 16'd2080, 2'd0, 2'd0, 22'h000000, 1'b0, -1, 10'd0, 1'b0, 0,  6'd0, 3, 1000};
        vecs[7] = '{1'b0, 16'd96,   2'd2, 2'd3, 22'h155555, 1'b0, -1, 10'd0, 1'b1, 32, 6'd2, 3, 976};

        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        rel_valid = 1'b0;
        rel_words = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset wr_en", wr_en, 0);
        check("reset meta_valid", meta_valid, 0);
        check("reset meta_addr", meta_addr, 0);
        check("reset meta_len", meta_len, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("reset free_words", free_words, DEPTH);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_reset) apply_reset();
            build_packet(vecs[v].len, vecs[v].dst, vecs[v].src, vecs[v].ts);
            drive_words(vecs[v].gapped, vecs[v].rel_at, vecs[v].rel_n);
            settle();
            check_packet($sformatf("vec%0d", v), vecs[v].exp_acc, vecs[v].exp_addr, vecs[v].exp_len);
            check($sformatf("vec%0d drop_cnt", v), drop_cnt, vecs[v].exp_drop);
            check($sformatf("vec%0d free_words", v), free_words, vecs[v].exp_free);
        end

        // Fill to wr_ptr=1016, free=8, then a 16-word packet that wraps the buffer.
        apply_reset();
        build_packet(16'd2048, 2'd1, 2'd0, 22'h0ABCDE);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("fill2048", 1'b1, 0, 6'd63);
        build_packet(16'd2016, 2'd2, 2'd1, 22'h30F0F0);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("fill2016", 1'b1, 512, 6'd62);
        check("fill free_words", free_words, 8);
        release_words(10'd8);
        check("release free_words", free_words, 16);
        build_packet(16'd64, 2'd3, 2'd3, 22'h1C0DE5);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("wrap", 1'b1, 1016, 6'd1);
        check("wrap free_words", free_words, 0);

        // Full buffer: 16 words with only 8 free must be skipped, then 8 words fit.
        release_words(10'd8);
        check("full free_words", free_words, 8);
        build_packet(16'd64, 2'd1, 2'd1, 22'h000777);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("full drop", 1'b0, 0, 6'd0);
        check("full drop_cnt", drop_cnt, 1);
        check("full drop free_words", free_words, 8);
        build_packet(16'd32, 2'd2, 2'd0, 22'h2FEDCB);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("after full", 1'b1, 8, 6'd0);
        check("after full free_words", free_words, 0);

        // Reset asserted mid-payload clears outputs at once; next packet starts at 0.
        release_words(10'd512);
        check("pre-reset free_words", free_words, 512);
        build_packet(16'd64, 2'd1, 2'd2, 22'h011111);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            pkt_valid = 1'b1;
            pkt_data  = pkt_q[i];
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("midreset wr_en", wr_en, 0);
        check("midreset meta_valid", meta_valid, 0);
        check("midreset wr_addr", wr_addr, 0);
        check("midreset meta_addr", meta_addr, 0);
        check("midreset drop_cnt", drop_cnt, 0);
        check("midreset free_words", free_words, DEPTH);
        pkt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        build_packet(16'd32, 2'd3, 2'd1, 22'h123456);
        drive_words(1'b0, -1, 10'd0);
        settle();
        check_packet("post reset", 1'b1, 0, 6'd0);
        check("post reset free_words", free_words, 1016);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/packet_rx.md
Name: packet_rx

Overview:
- Ingress stage directly downstream of the per-port packet generator.
- Consumes the generator's 32-bit word stream and parses the six header words: length/DMAC, DMAC, timestamp x2, SMAC x2.
- Writes every word of an accepted packet into a circular word buffer.
- When a packet completes, emits one metadata record (src port, dest port, length, start address, timestamp) to the scheduler/VOQ.
- Drops packets that do not fit in the buffer or that carry an illegal length.

Parameters:
BUF_DEPTH, 1024, buffer size in 32-bit words; power of two, minimum 512.
ADDR_W, $clog2(BUF_DEPTH), buffer word-address width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pkt_valid  in  1  word on pkt_data is valid this cycle (driven by the generator's packet_ready)
pkt_data  in  32  packet word
rel_valid  in  1  consumer releases buffer space this cycle
rel_words  in  10  number of words released (8..512)
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  32  buffer write data
meta_valid  out  1  one-cycle pulse: metadata record valid
meta_src  out  2  source port
meta_dst  out  2  destination port
meta_len  out  6  packet length in 32-byte blocks minus 1 (0..63)
meta_addr  out  ADDR_W  buffer address of header word 0
meta_ts  out  22  timestamp field
drop_cnt  out  16  count of dropped packets; saturates at 0xFFFF
free_words  out  ADDR_W+1  current free buffer words

Behaviour:
- Reset: async, active-low. Clears wr_en, meta_valid, all meta_* outputs, wr_ptr, used count and drop_cnt. free_words = BUF_DEPTH. State = HDR0.
- A word is consumed only in a cycle where pkt_valid=1. With pkt_valid=0 the state machine holds and no write occurs.
- Word decoding:
  - Word 0: bits [31:16] = length in bytes (L); bits [15:0] = DMAC[47:32].
  - Word 1: DMAC[31:0]; dest port = bits [1:0].
  - Word 2: timestamp; meta_ts = bits [21:0].
  - Word 3: ignored.
  - Word 4: src port = bits [1:0].
  - Word 5: ignored.
  - Words 6 and up: payload.
- Total word count: W = L/4.
- Length legality: L must be nonzero, a multiple of 32, and at most 2048. Then W is in 8..512 and meta_len = L/32 - 1.
- States: HDR0, HDR1, TS0, TS1, SMAC0, SMAC1, PAYLOAD, DROP.
- HDR0 decision, on the valid word 0:
  - Illegal L: go to DROP with remaining = 0, so the next valid word is treated as a new word 0 (resynchronisation). Increment drop_cnt.
  - Legal L but W > free_words: go to DROP with remaining = W-1. Increment drop_cnt.
  - Otherwise accept: reserve W words, latch start = wr_ptr, write word 0, set remaining = W-1, go to HDR1.
- Accepted words advance HDR1, TS0, TS1, SMAC0, SMAC1, PAYLOAD, one state per valid word, each written to the buffer.
- PAYLOAD: decrement remaining on each valid word. The valid word for which remaining reaches 0 is the last word; after it, return to HDR0.
- DROP: consume valid words without writing, decrementing remaining. When remaining reaches 0, return to HDR0.
- Write timing: wr_en, wr_addr and wr_data are registered and asserted the cycle after the word is accepted. wr_ptr increments modulo BUF_DEPTH, so writes wrap from BUF_DEPTH-1 to 0.
- Metadata timing: meta_valid pulses for one cycle, coincident with the wr_en of the last word. meta_* hold their values until the next pulse.
- Buffer accounting:
  - used increases by W at accept and decreases by rel_words on rel_valid.
  - Accept and release in the same cycle: both apply.
  - The accept decision uses free_words before that cycle's release (conservative).
  - Release when used < rel_words: clamp used to 0 (protocol error).
- Reset mid-packet: the partial packet is discarded, no metadata is emitted, and the parser restarts in HDR0.

Test Plan:
- Single minimum packet: L=32 (8 words) with pkt_valid held high -> 8 writes at addr 0..7; meta_valid with the 8th write; meta_len=0, meta_addr=0, meta_dst/src/ts match header words; free_words=1016.
- Gapped stream: L=64 with pkt_valid toggling 1/0 -> 16 writes at addr 0..15, no extra or missing writes; meta_len=1.
- Wrap-around: BUF_DEPTH=1024, wr_ptr=1020, free_words sufficient, L=64 -> writes at 1020..1023 then 0..11; meta_addr=1020.
- Full buffer: fill until free_words=8, then send L=64 -> 16 words consumed with no wr_en, drop_cnt=1, no meta_valid; the next L=32 packet is accepted.
- Illegal length: word 0 with L=40 -> drop_cnt increments; the next valid word is parsed as a fresh word 0, and a legal packet following it is accepted.
- Simultaneous events: rel_valid with rel_words=8 in the same cycle as accepting an L=32 packet -> net used unchanged. Also assert reset (low) mid-PAYLOAD -> outputs cleared immediately, next packet lands at addr 0.
